// File: rtl/imem_loader.sv
// imem_loader: packs a 3-byte-per-instruction stream into instruction memory and holds the CPU while loading
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int INST_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              im_wr_en,
    output logic [ADDR_W-1:0] im_wr_addr,
    output logic [INST_W-1:0] im_wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] words_loaded
);
    typedef enum logic [3:0] {IDLE, HDR, B0, B1, B2, WRITE, CHK, DONE, ERR} state_t;

    state_t              state_q, state_d;
    logic [7:0]          len_q, len_d;
    logic                b0_q, b0_d;
    logic [7:0]          b1_q, b1_d;
    logic [7:0]          acc_q, acc_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [INST_W-1:0]   data_q, data_d;
    logic [ADDR_W-1:0]   words_q, words_d;
    logic                hold_q, hold_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                xfer;

    assign byte_ready   = state_q inside {HDR, B0, B1, B2, CHK};
    assign im_wr_en     = state_q == WRITE;
    assign im_wr_addr   = addr_q;
    assign im_wr_data   = data_q;
    assign cpu_hold     = hold_q;
    assign done         = done_q;
    assign error        = err_q;
    assign words_loaded = words_q;
    assign xfer         = byte_valid && byte_ready;

    // Next-state: every accepted byte feeds the checksum; the final byte must bring the sum to zero
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        acc_d   = xfer ? acc_q + byte_in : acc_q;
        addr_d  = addr_q;
        data_d  = data_q;
        words_d = words_q;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = HDR;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    words_d = '0;
                    acc_d   = '0;
                    addr_d  = '0;
                    hold_d  = 1'b1;
                end
            end
            HDR: begin
                if (xfer) begin
                    state_d = (byte_in == 8'd0) ? ERR : B0;
                    err_d   = byte_in == 8'd0;
                    len_d   = byte_in;
                end
            end
            B0: begin
                if (xfer) begin
                    state_d = |byte_in[7:1] ? ERR : B1;
                    err_d   = |byte_in[7:1];
                    b0_d    = byte_in[0];
                end
            end
            B1: begin
                if (xfer) begin
                    state_d = B2;
                    b1_d    = byte_in;
                end
            end
            B2: begin
                if (xfer) begin
                    state_d = WRITE;
                    data_d  = {b0_q, b1_q, byte_in};
                end
            end
            WRITE: begin
                addr_d  = addr_q + 1'b1;
                words_d = words_q + 1'b1;
                state_d = (words_d == ADDR_W'(len_q)) ? CHK : B0;
            end
            CHK: begin
                if (xfer) begin
                    state_d = (acc_d == 8'd0) ? DONE : ERR;
                    done_d  = acc_d == 8'd0;
                    err_d   = acc_d != 8'd0;
                    hold_d  = acc_d != 8'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; async reset drops any session and releases the CPU
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            b0_q    <= 1'b0;
            b1_q    <= '0;
            acc_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            words_q <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            acc_q   <= acc_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            words_q <= words_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed scenario tests for the instruction-memory loader
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        im_wr_en;
    logic [7:0]  im_wr_addr;
    logic [16:0] im_wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [7:0]  words_loaded;

    int tests = 0;
    int fails = 0;
    int wr_n = 0;
    logic [7:0]  wr_addr_log [32];
    logic [16:0] wr_data_log [32];

    imem_loader dut (
        .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .im_wr_en(im_wr_en), .im_wr_addr(im_wr_addr),
        .im_wr_data(im_wr_data), .cpu_hold(cpu_hold), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Log every write strobe seen at the falling edge (strobe is one full cycle wide)
    always @(negedge clk) begin
        if (im_wr_en && wr_n < 32) begin
            wr_addr_log[wr_n] = im_wr_addr;
            wr_data_log[wr_n] = im_wr_data;
            wr_n++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) @(negedge clk);
        byte_in = b;
        byte_valid = 1'b1;
        t = 0;
        while (!byte_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!byte_ready) begin
            tests++;
            fails++;
            $display("FAIL send_byte timeout: byte_ready=%b required 1 for byte %h", byte_ready, b);
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if ({byte_ready, im_wr_en, im_wr_addr, im_wr_data, cpu_hold, done, error, words_loaded} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: ready=%b wr=%b addr=%h data=%h hold=%b done=%b err=%b words=%h, all required 0",
                     byte_ready, im_wr_en, im_wr_addr, im_wr_data, cpu_hold, done, error, words_loaded);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (byte_ready !== 1'b0 || cpu_hold !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: ready=%b hold=%b required 0 0", byte_ready, cpu_hold);
        end
    endtask

    task automatic test_single();
        int base;
        base = wr_n;
        pulse_start();
        tests++;
        if (cpu_hold !== 1'b1 || byte_ready !== 1'b1) begin
            fails++;
            $display("FAIL single_hdr: hold=%b ready=%b required 1 1", cpu_hold, byte_ready);
        end
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h3C, 0);
        send_byte(8'h1D, 0);
        @(negedge clk);
        tests++;
        if (wr_n - base !== 1 || wr_addr_log[base] !== 8'h00 || wr_data_log[base] !== 17'h1A53C) begin
            fails++;
            $display("FAIL single_write: n=%0d addr=%h data=%h required 1 00 1a53c",
                     wr_n - base, wr_addr_log[base], wr_data_log[base]);
        end
        tests++;
        if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0 || words_loaded !== 8'd1) begin
            fails++;
            $display("FAIL single_done: done=%b err=%b hold=%b words=%0d required 1 0 0 1",
                     done, error, cpu_hold, words_loaded);
        end
        byte_in = 8'h01;
        byte_valid = 1'b1;
        repeat (3) @(negedge clk);
        byte_valid = 1'b0;
        tests++;
        if (byte_ready !== 1'b0 || wr_n - base !== 1 || done !== 1'b1) begin
            fails++;
            $display("FAIL done_ignores_bytes: ready=%b n=%0d done=%b required 0 1 1", byte_ready, wr_n - base, done);
        end
    endtask

    task automatic test_three_random();
        logic [7:0] s [11];
        int base;
        s = '{8'h03, 8'h00, 8'h12, 8'h34, 8'h01, 8'hFF, 8'h00, 8'h00, 8'hAB, 8'hCD, 8'h3F};
        base = wr_n;
        pulse_start();
        for (int i = 0; i < 11; i++) send_byte(s[i], $urandom_range(0, 3));
        @(negedge clk);
        tests++;
        if (wr_n - base !== 3 || wr_addr_log[base] !== 8'd0 || wr_addr_log[base+1] !== 8'd1 || wr_addr_log[base+2] !== 8'd2) begin
            fails++;
            $display("FAIL three_addrs: n=%0d addrs=%h %h %h required 3 00 01 02",
                     wr_n - base, wr_addr_log[base], wr_addr_log[base+1], wr_addr_log[base+2]);
        end
        tests++;
        if (wr_data_log[base] !== 17'h01234 || wr_data_log[base+1] !== 17'h1FF00 || wr_data_log[base+2] !== 17'h0ABCD) begin
            fails++;
            $display("FAIL three_data: %h %h %h required 01234 1ff00 0abcd",
                     wr_data_log[base], wr_data_log[base+1], wr_data_log[base+2]);
        end
        tests++;
        if (words_loaded !== 8'd3 || done !== 1'b1 || cpu_hold !== 1'b0) begin
            fails++;
            $display("FAIL three_done: words=%0d done=%b hold=%b required 3 1 0", words_loaded, done, cpu_hold);
        end
    endtask

    task automatic test_bad_b0();
        int base;
        base = wr_n;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        repeat (3) @(negedge clk);
        tests++;
        if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1 || wr_n != base || byte_ready !== 1'b0) begin
            fails++;
            $display("FAIL bad_b0: err=%b done=%b hold=%b writes=%0d ready=%b required 1 0 1 0 0",
                     error, done, cpu_hold, wr_n - base, byte_ready);
        end
        pulse_start();
        tests++;
        if (error !== 1'b0 || cpu_hold !== 1'b1) begin
            fails++;
            $display("FAIL restart_clears: err=%b hold=%b required 0 1", error, cpu_hold);
        end
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h3C, 0);
        send_byte(8'h1D, 0);
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || error !== 1'b0 || wr_n - base !== 1 || wr_addr_log[base] !== 8'd0) begin
            fails++;
            $display("FAIL recover_after_err: done=%b err=%b writes=%0d addr=%h required 1 0 1 00",
                     done, error, wr_n - base, wr_addr_log[base]);
        end
    endtask

    task automatic test_len_zero();
        pulse_start();
        send_byte(8'h00, 0);
        @(negedge clk);
        tests++;
        if (error !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL len_zero: err=%b hold=%b done=%b required 1 1 0", error, cpu_hold, done);
        end
    endtask

    task automatic test_bad_chk();
        int base;
        base = wr_n;
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'hFB, 0);
        @(negedge clk);
        tests++;
        if (wr_n - base !== 2 || wr_data_log[base] !== 17'h00001 || wr_data_log[base+1] !== 17'h10002 || wr_addr_log[base+1] !== 8'd1) begin
            fails++;
            $display("FAIL bad_chk_writes: n=%0d d0=%h d1=%h a1=%h required 2 00001 10002 01",
                     wr_n - base, wr_data_log[base], wr_data_log[base+1], wr_addr_log[base+1]);
        end
        tests++;
        if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1 || words_loaded !== 8'd2) begin
            fails++;
            $display("FAIL bad_chk_status: err=%b done=%b hold=%b words=%0d required 1 0 1 2",
                     error, done, cpu_hold, words_loaded);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        base = wr_n;
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h00, 0);
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({byte_ready, im_wr_en, im_wr_addr, im_wr_data, cpu_hold, done, error, words_loaded} !== '0) begin
            fails++;
            $display("FAIL mid_reset_outputs: ready=%b wr=%b addr=%h data=%h hold=%b words=%h, all required 0",
                     byte_ready, im_wr_en, im_wr_addr, im_wr_data, cpu_hold, words_loaded);
        end
        tests++;
        if (wr_n - base !== 1 || wr_data_log[base] !== 17'h01122) begin
            fails++;
            $display("FAIL mid_reset_writes: n=%0d d0=%h required 1 01122", wr_n - base, wr_data_log[base]);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h3C, 0);
        send_byte(8'h1D, 0);
        @(negedge clk);
        tests++;
        if (wr_n - base !== 2 || wr_addr_log[base+1] !== 8'd0 || done !== 1'b1) begin
            fails++;
            $display("FAIL after_reset_addr: n=%0d addr=%h done=%b required 2 00 1", wr_n - base, wr_addr_log[base+1], done);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_three_random();
        test_bad_b0();
        test_len_zero();
        test_bad_chk();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
